data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory answering one request at a time after LATENCY wait cycles.
// Optional feature macro MEM_RANGE_CHECK_EN adds the err output and rejects addresses beyond storage.
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] address_data,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [3:0] C_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam int         C_DEPTH    = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_write;
  logic                 w_accept;
  logic                 w_enter_done;
  logic [31:0]          w_acc_addr;
  logic [31:0]          w_acc_wdata;
  logic                 w_acc_write;
  logic                 w_acc_ok;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          r_mem [C_DEPTH];

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With zero latency the access completes on the accepting edge, so it uses the live inputs.
  assign w_acc_addr  = (r_state == S_IDLE) ? address_data : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? data_in      : r_wdata;
  assign w_acc_write = (r_state == S_IDLE) ? req_write    : r_write;
  assign w_idx       = w_acc_addr[ADDR_BITS-1:0];

`ifdef MEM_RANGE_CHECK_EN
  assign w_acc_ok = ~|w_acc_addr[31:ADDR_BITS];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_acc_addr[31:ADDR_BITS];
  assign w_acc_ok    = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_write  <= 1'b0;
      data_out <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= address_data;
        r_wdata <= data_in;
        r_write <= req_write;
      end
      if (w_enter_done && !w_acc_write) begin
        data_out <= w_acc_ok ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_done && w_acc_write && w_acc_ok) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= w_enter_done && !w_acc_ok;
    end
  end
`endif

  assign ready = (r_state == S_DONE);
  assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a LATENCY=2 and a LATENCY=0 instance sharing clock and reset.
// Range-check scenarios follow MEM_RANGE_CHECK_EN.
`default_nettype none

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v2 = 1'b0, w2 = 1'b0;
  logic [31:0] a2 = 32'd0, d2 = 32'd0;
  logic [31:0] q2;
  logic        rdy2, bsy2;
  logic        v0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = 32'd0, d0 = 32'd0;
  logic [31:0] q0;
  logic        rdy0, bsy0;
`ifdef MEM_RANGE_CHECK_EN
  logic        e2, e0;
  logic        r_er;
`endif
  logic        r_got;
  logic [31:0] r_rd;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_write(w2),
    .address_data(a2), .data_in(d2), .data_out(q2), .ready(rdy2), .busy(bsy2)
`ifdef MEM_RANGE_CHECK_EN
    , .err(e2)
`endif
  );

  data_mem_responder #(.ADDR_BITS(8), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_write(w0),
    .address_data(a0), .data_in(d0), .data_out(q0), .ready(rdy0), .busy(bsy0)
`ifdef MEM_RANGE_CHECK_EN
    , .err(e0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one transaction on the LATENCY=2 instance and waits (bounded) for ready.
  task automatic tx2(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    r_got = 1'b0;
    r_rd  = 32'd0;
`ifdef MEM_RANGE_CHECK_EN
    r_er  = 1'b0;
`endif
    v2 = 1'b1; w2 = wr; a2 = addr; d2 = data;
    tick();
    v2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy2) begin
        r_got = 1'b1;
        r_rd  = q2;
`ifdef MEM_RANGE_CHECK_EN
        r_er  = e2;
`endif
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL reset_ready_l2: got %b expected 0", rdy2); end
    checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL reset_busy_l2: got %b expected 0", bsy2); end
    checks++; if (q2 !== 32'd0) begin failures++; $display("FAIL reset_dout_l2: got %h expected 00000000", q2); end
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready_l0: got %b expected 0", rdy0); end
    checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL reset_busy_l0: got %b expected 0", bsy0); end
    checks++; if (q0 !== 32'd0) begin failures++; $display("FAIL reset_dout_l0: got %h expected 00000000", q0); end
`ifdef MEM_RANGE_CHECK_EN
    checks++; if (e2 !== 1'b0) begin failures++; $display("FAIL reset_err_l2: got %b expected 0", e2); end
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL release_busy_l2: got %b expected 0", bsy2); end
  endtask

  task automatic test_write();
    v2 = 1'b1; w2 = 1'b1; a2 = 32'd5; d2 = 32'hDEADBEEF;
    tick();
    v2 = 1'b0;
    checks++; if (bsy2 !== 1'b1) begin failures++; $display("FAIL wr_busy_e0: got %b expected 1", bsy2); end
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL wr_ready_e0: got %b expected 0", rdy2); end
    tick();
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL wr_ready_e1: got %b expected 0", rdy2); end
    tick();
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL wr_ready_e2: got %b expected 1", rdy2); end
    checks++; if (q2 !== 32'd0) begin failures++; $display("FAIL wr_dout_done: got %h expected 00000000", q2); end
    tick();
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL wr_ready_after: got %b expected 0", rdy2); end
    checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL wr_busy_after: got %b expected 0", bsy2); end
    checks++; if (q2 !== 32'd0) begin failures++; $display("FAIL wr_dout_after: got %h expected 00000000", q2); end
  endtask

  task automatic test_read();
    v2 = 1'b1; w2 = 1'b0; a2 = 32'd5;
    tick();
    v2 = 1'b0;
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL rd_ready_e0: got %b expected 0", rdy2); end
    tick();
    tick();
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL rd_ready_e2: got %b expected 1", rdy2); end
    checks++; if (q2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_dout_done: got %h expected deadbeef", q2); end
    tick();
    checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL rd_busy_after: got %b expected 0", bsy2); end
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL rd_ready_after: got %b expected 0", rdy2); end
    tick();
    tick();
    checks++; if (q2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_dout_hold: got %h expected deadbeef", q2); end
  endtask

  task automatic test_back_to_back();
    v0 = 1'b1; w0 = 1'b1; a0 = 32'd3; d0 = 32'h11;
    tick();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_ready_wr: got %b expected 1", rdy0); end
    checks++; if (q0 !== 32'd0) begin failures++; $display("FAIL b2b_dout_wr: got %h expected 00000000", q0); end
    w0 = 1'b0;
    tick();
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_ready_gap: got %b expected 0", rdy0); end
    checks++; if (bsy0 !== 1'b0) begin failures++; $display("FAIL b2b_busy_gap: got %b expected 0", bsy0); end
    tick();
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_ready_rd: got %b expected 1", rdy0); end
    checks++; if (q0 !== 32'h11) begin failures++; $display("FAIL b2b_dout_rd: got %h expected 00000011", q0); end
    v0 = 1'b0;
    tick();
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_ready_end: got %b expected 0", rdy0); end
    checks++; if (q0 !== 32'h11) begin failures++; $display("FAIL b2b_dout_end: got %h expected 00000011", q0); end
  endtask

  task automatic test_capture();
    tx2(1'b1, 32'd10, 32'h10101010);
    checks++; if (r_got !== 1'b1) begin failures++; $display("FAIL cap_prewrite_timeout: got %b expected 1", r_got); end
    v2 = 1'b1; w2 = 1'b1; a2 = 32'd9; d2 = 32'hA5A5A5A5;
    tick();
    a2 = 32'd10; d2 = 32'hFFFF0000; w2 = 1'b0;
    tick();
    a2 = 32'd11; d2 = 32'h00001234;
    tick();
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL cap_ready: got %b expected 1", rdy2); end
    v2 = 1'b0;
    tick();
    tx2(1'b0, 32'd9, 32'd0);
    checks++; if (r_rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL cap_addr9: got %h expected a5a5a5a5", r_rd); end
    tx2(1'b0, 32'd10, 32'd0);
    checks++; if (r_rd !== 32'h10101010) begin failures++; $display("FAIL cap_addr10: got %h expected 10101010", r_rd); end
  endtask

  task automatic test_reset_abort();
    tx2(1'b1, 32'd7, 32'h77);
    checks++; if (r_got !== 1'b1) begin failures++; $display("FAIL abort_prewrite_timeout: got %b expected 1", r_got); end
    v2 = 1'b1; w2 = 1'b1; a2 = 32'd7; d2 = 32'h55;
    tick();
    v2 = 1'b0;
    checks++; if (bsy2 !== 1'b1) begin failures++; $display("FAIL abort_busy_wait: got %b expected 1", bsy2); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bsy2 !== 1'b0) begin failures++; $display("FAIL abort_busy_async: got %b expected 0", bsy2); end
    checks++; if (q2 !== 32'd0) begin failures++; $display("FAIL abort_dout_async: got %h expected 00000000", q2); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL abort_ready_in_reset: got %b expected 0", rdy2); end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL abort_ready_after: got %b expected 0", rdy2); end
    end
    tx2(1'b0, 32'd7, 32'd0);
    checks++; if (r_got !== 1'b1) begin failures++; $display("FAIL abort_read_timeout: got %b expected 1", r_got); end
    checks++; if (r_rd !== 32'h77) begin failures++; $display("FAIL abort_addr7: got %h expected 00000077", r_rd); end
  endtask

  task automatic test_range();
    tx2(1'b1, 32'd5, 32'h5A5A5A5A);
    checks++; if (r_got !== 1'b1) begin failures++; $display("FAIL range_prewrite_timeout: got %b expected 1", r_got); end
    tx2(1'b1, 32'h00000105, 32'hCAFEF00D);
    checks++; if (r_got !== 1'b1) begin failures++; $display("FAIL range_write_timeout: got %b expected 1", r_got); end
`ifdef MEM_RANGE_CHECK_EN
    checks++; if (r_er !== 1'b1) begin failures++; $display("FAIL range_err_write: got %b expected 1", r_er); end
    checks++; if (e2 !== 1'b0) begin failures++; $display("FAIL range_err_after: got %b expected 0", e2); end
    tx2(1'b0, 32'd5, 32'd0);
    checks++; if (r_rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL range_addr5_kept: got %h expected 5a5a5a5a", r_rd); end
    checks++; if (r_er !== 1'b0) begin failures++; $display("FAIL range_err_inrange: got %b expected 0", r_er); end
    tx2(1'b0, 32'h00000105, 32'd0);
    checks++; if (r_rd !== 32'd0) begin failures++; $display("FAIL range_read_oor: got %h expected 00000000", r_rd); end
    checks++; if (r_er !== 1'b1) begin failures++; $display("FAIL range_err_read: got %b expected 1", r_er); end
`else
    tx2(1'b0, 32'd5, 32'd0);
    checks++; if (r_rd !== 32'hCAFEF00D) begin failures++; $display("FAIL range_alias_addr5: got %h expected cafef00d", r_rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_capture();
    test_reset_abort();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
